// File: rtl/puf_challenge_controller_if.sv
// Bus between a PUF evaluation requester and puf_challenge_controller.
// Optional macro PUF_VOTE_COUNT_EN adds the VoteOnes / Unstable diagnostics.
//   master : requester side (drives Start, ChallengeIn, ArbiterOut)
//   slave  : controller side (drives Challenge, Launch, Busy, Done, Response)
interface puf_challenge_controller_if #(
    parameter int CHAL_W = 64,
    parameter int VOTES  = 5
);
    localparam int VW = $clog2(VOTES + 1);

    logic              Start;
    logic [CHAL_W-1:0] ChallengeIn;
    logic              ArbiterOut;
    logic [CHAL_W-1:0] Challenge;
    logic              Launch;
    logic              Busy;
    logic              Done;
    logic              Response;
`ifdef PUF_VOTE_COUNT_EN
    logic [VW-1:0]     VoteOnes;
    logic              Unstable;
`endif

`ifdef PUF_VOTE_COUNT_EN
    modport master (output Start, ChallengeIn, ArbiterOut,
                    input  Challenge, Launch, Busy, Done, Response, VoteOnes, Unstable);
    modport slave  (input  Start, ChallengeIn, ArbiterOut,
                    output Challenge, Launch, Busy, Done, Response, VoteOnes, Unstable);
`else
    modport master (output Start, ChallengeIn, ArbiterOut,
                    input  Challenge, Launch, Busy, Done, Response);
    modport slave  (input  Start, ChallengeIn, ArbiterOut,
                    output Challenge, Launch, Busy, Done, Response);
`endif
endinterface

// File: rtl/puf_challenge_controller.sv
// Arbiter-PUF evaluation sequencer: latches a challenge onto the switch-block
// chain, fires VOTES races separated by settle gaps, and returns the
// majority-voted arbiter bit with a one-cycle Done pulse.
// Optional macro PUF_VOTE_COUNT_EN adds VoteOnes (ones count) and Unstable.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - asynchronous active-high reset
//   bus    - slave modport: Start/ChallengeIn/ArbiterOut in,
//            Challenge/Launch/Busy/Done/Response out
module puf_challenge_controller #(
    parameter int CHAL_W        = 64,
    parameter int VOTES         = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int RACE_CYCLES   = 2
) (
    input logic                      Clk,
    input logic                      Reset,
    puf_challenge_controller_if.slave bus
);
    localparam int VW   = $clog2(VOTES + 1);
    localparam int MAXP = (SETTLE_CYCLES > RACE_CYCLES) ? SETTLE_CYCLES : RACE_CYCLES;
    localparam int PW   = $clog2(MAXP + 1);

    localparam logic [VW-1:0] VOTES_C    = VW'(VOTES);
    localparam logic [VW-1:0] HALF_C     = VW'(VOTES / 2);
    localparam logic [PW-1:0] SETTLE_END = PW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] RACE_END   = PW'(RACE_CYCLES - 1);

    generate
        if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
            $error("VOTES must be odd and >= 1");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= 1");
        end
        if (RACE_CYCLES < 1) begin : g_bad_race
            $error("RACE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRE, S_SAMPLE, S_REARM, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [VW-1:0]     vidx_q, vidx_d;
    logic [VW-1:0]     ones_q, ones_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              launch_q, launch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              resp_q, resp_d;
    logic              phase_last;
`ifdef PUF_VOTE_COUNT_EN
    logic [VW-1:0]     vote_ones_q, vote_ones_d;
    logic              unstable_q, unstable_d;
`endif

    // State register and all output/counter flops
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            vidx_q      <= '0;
            ones_q      <= '0;
            chal_q      <= '0;
            launch_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= 1'b0;
`ifdef PUF_VOTE_COUNT_EN
            vote_ones_q <= '0;
            unstable_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            vidx_q      <= vidx_d;
            ones_q      <= ones_d;
            chal_q      <= chal_d;
            launch_q    <= launch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
`ifdef PUF_VOTE_COUNT_EN
            vote_ones_q <= vote_ones_d;
            unstable_q  <= unstable_d;
`endif
        end
    end

    // Next-state logic; phase counts cycles spent in the current timed state
    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            S_LOAD, S_REARM: phase_last = (phase_q == SETTLE_END);
            S_FIRE:          phase_last = (phase_q == RACE_END);
            default:         phase_last = 1'b0;
        endcase

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.Start) state_d = S_LOAD;
            S_LOAD:   if (phase_last) state_d = S_FIRE;
            S_FIRE:   if (phase_last) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_REARM;
            S_REARM:  if (phase_last) state_d = (vidx_q == VOTES_C) ? S_DONE : S_FIRE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        phase_d = (state_d == state_q && state_q != S_IDLE) ? phase_q + 1'b1 : '0;
    end

    // Output/datapath next values. Outputs are decoded from the next state so
    // Launch/Busy/Done come straight from flops.
    always_comb begin
        chal_d = chal_q;
        vidx_d = vidx_q;
        ones_d = ones_q;
        resp_d = resp_q;
`ifdef PUF_VOTE_COUNT_EN
        vote_ones_d = vote_ones_q;
        unstable_d  = unstable_q;
`endif

        if (state_q == S_IDLE && bus.Start) begin
            chal_d = bus.ChallengeIn;
            vidx_d = '0;
            ones_d = '0;
        end

        if (state_q == S_SAMPLE) begin
            ones_d = ones_q + VW'(bus.ArbiterOut);
            vidx_d = vidx_q + 1'b1;
        end

        // Vote is final by the time REARM exits, so resolve on DONE entry
        if (state_d == S_DONE && state_q != S_DONE) begin
            resp_d = (ones_q > HALF_C);
`ifdef PUF_VOTE_COUNT_EN
            vote_ones_d = ones_q;
            unstable_d  = (ones_q != '0) && (ones_q != VOTES_C);
`endif
        end

        launch_d = (state_d == S_FIRE) || (state_d == S_SAMPLE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    assign bus.Challenge = chal_q;
    assign bus.Launch    = launch_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Response  = resp_q;
`ifdef PUF_VOTE_COUNT_EN
    assign bus.VoteOnes  = vote_ones_q;
    assign bus.Unstable  = unstable_q;
`endif
endmodule
